// File: rtl/song_reader.sv
// Song ROM sequencer: walks note slots of the selected song and hands notes to the player.
// Optional SONG_REPEAT_EN: restart the song from slot 0 at its end instead of waiting for play=0.
module song_reader #(
    parameter int IDX_W  = 5,
    parameter int SONG_W = 2
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    play,
    input  logic [SONG_W-1:0]       song,
    input  logic                    note_done,
    output logic [SONG_W+IDX_W-1:0] rom_addr,
    input  logic [11:0]             rom_data,
    output logic [5:0]              note_to_load,
    output logic [5:0]              duration_to_load,
    output logic                    load_new_note,
    output logic                    song_done
);

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        WAIT_ROM,
        LOAD,
        WAIT_DONE,
        END
    } state_t;

    state_t             state_q, state_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [SONG_W-1:0]  song_q, song_d;
    logic [5:0]         note_q, note_d;
    logic [5:0]         dur_q, dur_d;
    logic               done_q, done_d;

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        song_d  = song_q;
        note_d  = note_q;
        dur_d   = dur_q;
        unique case (state_q)
            IDLE: begin
                if (play) begin
                    song_d  = song;
                    idx_d   = '0;
                    state_d = FETCH;
                end
            end
            FETCH: state_d = WAIT_ROM;
            WAIT_ROM: begin
                note_d  = rom_data[11:6];
                dur_d   = rom_data[5:0];
                // A zero duration marks the end of the song
                state_d = (rom_data[5:0] != '0) ? LOAD : END;
            end
            LOAD: state_d = WAIT_DONE;
            WAIT_DONE: begin
                if (note_done) begin
                    if (idx_q == {IDX_W{1'b1}}) begin
                        state_d = END;
                    end else begin
                        idx_d   = idx_q + IDX_W'(1);
                        state_d = FETCH;
                    end
                end
            end
            END: begin
`ifdef SONG_REPEAT_EN
                if (play) begin
                    idx_d   = '0;
                    state_d = FETCH;
                end else begin
                    state_d = IDLE;
                end
`else
                if (!play) state_d = IDLE;
`endif
            end
            default: state_d = IDLE;
        endcase
        done_d = (state_d == END) && (state_q != END);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            idx_q   <= '0;
            song_q  <= '0;
            note_q  <= '0;
            dur_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            song_q  <= song_d;
            note_q  <= note_d;
            dur_q   <= dur_d;
            done_q  <= done_d;
        end
    end

    // Strobes are masked while reset is held so none leak out mid-note
    assign rom_addr         = {song_q, idx_q};
    assign note_to_load     = note_q;
    assign duration_to_load = dur_q;
    assign load_new_note    = (state_q == LOAD) && !reset;
    assign song_done        = done_q && !reset;

endmodule

// File: tb/tb_song_reader.sv
// Bench for song_reader: per-cycle comparison against a slot-walking model,
// plus directed literal scenarios and a randomized soak.
module tb_song_reader;

    logic        clk = 1'b0;
    logic        reset, play, note_done;
    logic [1:0]  song;
    logic [6:0]  rom_addr;
    logic [11:0] rom_data;
    logic [5:0]  note_to_load, duration_to_load;
    logic        load_new_note, song_done;

    logic [11:0] rom [0:127];
    int checks = 0;
    int errors = 0;
    bit started = 1'b0;

    always #5 clk = ~clk;

    song_reader #(.IDX_W(5), .SONG_W(2)) dut (
        .clk(clk),
        .reset(reset),
        .play(play),
        .song(song),
        .note_done(note_done),
        .rom_addr(rom_addr),
        .rom_data(rom_data),
        .note_to_load(note_to_load),
        .duration_to_load(duration_to_load),
        .load_new_note(load_new_note),
        .song_done(song_done)
    );

    // Synchronous ROM: data one clock after address
    always @(posedge clk) rom_data <= rom[rom_addr];

    // since: -1 = no fetch in flight; 0 addr cycle, 1 rom wait, 2 load cycle
    typedef struct {
        int         since;
        bit         wt;
        bit         en;
        bit         first;
        logic [1:0] sg;
        logic [4:0] idx;
        logic [5:0] nt;
        logic [5:0] du;
    } mdl_t;

    mdl_t m;

    function automatic mdl_t nxt(input mdl_t c, input logic r, input logic p,
                                 input logic [1:0] s, input logic nd);
        mdl_t n;
        logic [11:0] w;
        n = c;
        if (r) begin
            n.since = -1; n.wt = 0; n.en = 0; n.first = 0;
            n.sg = '0; n.idx = '0; n.nt = '0; n.du = '0;
            return n;
        end
        n.first = 0;
        if (c.since == 0) begin
            n.since = 1;
        end else if (c.since == 1) begin
            w = rom[{c.sg, c.idx}];
            n.nt = w[11:6];
            n.du = w[5:0];
            if (w[5:0] != 6'd0) n.since = 2;
            else begin n.since = -1; n.en = 1; n.first = 1; end
        end else if (c.since == 2) begin
            n.since = -1;
            n.wt = 1;
        end else if (c.wt) begin
            if (nd) begin
                n.wt = 0;
                if (c.idx == 5'd31) begin n.en = 1; n.first = 1; end
                else begin n.idx = c.idx + 5'd1; n.since = 0; end
            end
        end else if (c.en) begin
`ifdef SONG_REPEAT_EN
            n.en = 0;
            if (p) begin n.idx = '0; n.since = 0; end
`else
            if (!p) n.en = 0;
`endif
        end else if (p) begin
            n.sg = s; n.idx = '0; n.since = 0;
        end
        return n;
    endfunction

    always @(posedge clk) begin
        m <= nxt(m, reset, play, song, note_done);
        if (reset) started <= 1'b1;
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (started) begin
            chk("m_addr", 32'(rom_addr), 32'({m.sg, m.idx}));
            chk("m_load", 32'(load_new_note), 32'((m.since == 2) && !reset));
            chk("m_done", 32'(song_done), 32'(m.en && m.first && !reset));
            chk("m_note", 32'(note_to_load), 32'(m.nt));
            chk("m_dur", 32'(duration_to_load), 32'(m.du));
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1; play = 1'b0; note_done = 1'b0;
        repeat (2) cyc();
        reset = 1'b0;
    endtask

    task automatic chk_zero(input string nm);
        chk({nm, "_addr"}, 32'(rom_addr), 32'h0);
        chk({nm, "_load"}, 32'(load_new_note), 32'h0);
        chk({nm, "_done"}, 32'(song_done), 32'h0);
        chk({nm, "_note"}, 32'(note_to_load), 32'h0);
        chk({nm, "_dur"}, 32'(duration_to_load), 32'h0);
    endtask

    initial begin
        int cnt;
        bit pend;
        bit seen;
        logic [5:0] d;
        reset = 1'b1; play = 1'b0; song = 2'd0; note_done = 1'b0;
        for (int i = 0; i < 128; i++) begin
            d = 6'($urandom_range(1, 63));
            if (i >= 64 && $urandom_range(0, 15) == 0) d = 6'd0;
            rom[i] = {6'($urandom_range(0, 63)), d};
        end
        rom[7'h40] = 12'h1C8;
        rom[7'h41] = 12'h285;
        rom[7'h42] = 12'h3C0;

        repeat (3) cyc();
        reset = 1'b0;
        @(negedge clk); chk_zero("rst");

        // Song 2 directed walk; cycle 0 is the IDLE cycle with play=1
        cyc(); play = 1'b1; song = 2'd2;
        cyc(); @(negedge clk); chk("c1_addr", 32'(rom_addr), 32'h40);
        cyc(); song = 2'd1;
        cyc(); @(negedge clk);
        chk("c3_load", 32'(load_new_note), 32'h1);
        chk("c3_note", 32'(note_to_load), 32'd7);
        chk("c3_dur", 32'(duration_to_load), 32'd8);
        cyc(); play = 1'b0;
        cyc();
        cyc(); note_done = 1'b1;
        cyc(); note_done = 1'b1;
        @(negedge clk); chk("n1_addr", 32'(rom_addr), 32'h41);
        cyc(); note_done = 1'b0;
        cyc(); note_done = 1'b1;
        @(negedge clk);
        chk("n3_load", 32'(load_new_note), 32'h1);
        chk("n3_note", 32'(note_to_load), 32'd10);
        chk("n3_dur", 32'(duration_to_load), 32'd5);
        cyc(); note_done = 1'b0; play = 1'b1;
        cyc(); @(negedge clk); chk("hold_addr", 32'(rom_addr), 32'h41);
        cyc(); note_done = 1'b1;
        cyc(); note_done = 1'b0;
        @(negedge clk); chk("z_addr", 32'(rom_addr), 32'h42);
        cyc();
        cyc(); @(negedge clk);
        chk("z_done", 32'(song_done), 32'h1);
        chk("z_load", 32'(load_new_note), 32'h0);
        cyc(); @(negedge clk); chk("z_done1", 32'(song_done), 32'h0);
`ifndef SONG_REPEAT_EN
        cyc(); @(negedge clk);
        chk("end_hold", 32'(rom_addr), 32'h42);
        chk("end_done", 32'(song_done), 32'h0);
        cyc(); play = 1'b0;
        cyc(); play = 1'b1;
        cyc(); @(negedge clk); chk("idle_restart", 32'(rom_addr), 32'h20);
`endif

        // Full 32-slot song
        do_reset();
        song = 2'd0; play = 1'b1;
        cnt = 0; pend = 0; seen = 0;
        for (int k = 0; k < 400 && !seen; k++) begin
            cyc(); note_done = pend; pend = 0;
            @(negedge clk);
            if (load_new_note) begin cnt++; pend = 1; end
            if (song_done) seen = 1;
        end
        chk("full_strobes", 32'(cnt), 32'd32);
        chk("full_done", 32'(seen), 32'h1);
`ifdef SONG_REPEAT_EN
        for (int k = 0; k < 10 && cnt < 33; k++) begin
            cyc(); note_done = 1'b0;
            @(negedge clk);
            if (load_new_note) begin
                cnt++;
                chk("rep_addr", 32'(rom_addr), 32'h0);
            end
        end
        chk("rep_strobe", 32'(cnt), 32'd33);
`endif

        // Song change ignored mid-song, then reset during note 5
        do_reset();
        play = 1'b1; song = 2'd1;
        cyc(); song = 2'd3;
        cnt = 0; pend = 0;
        for (int k = 0; k < 200 && cnt < 5; k++) begin
            cyc(); note_done = pend; pend = 0;
            @(negedge clk);
            if (load_new_note) begin
                cnt++;
                pend = (cnt < 5);
                chk("song_lock", 32'(rom_addr[6:5]), 32'd1);
            end
        end
        chk("note5_seen", 32'(cnt), 32'd5);
        cyc(); reset = 1'b1;
        cyc(); reset = 1'b0;
        @(negedge clk); chk_zero("midrst");
        cyc(); @(negedge clk); chk("rst_restart", 32'(rom_addr), 32'h60);

        // Randomized soak
        do_reset();
        play = 1'b1;
        for (int k = 0; k < 3000; k++) begin
            cyc();
            reset = ($urandom_range(0, 199) == 0);
            if ($urandom_range(0, 9) == 0) play = ~play;
            if ($urandom_range(0, 7) == 0) song = 2'($urandom_range(0, 3));
            note_done = ($urandom_range(0, 2) == 0);
        end
        cyc();
        @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
